// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA raster timing from a free-running horizontal/vertical
//   counter pair advanced on a pixel-rate clock enable. It requests pixel
//   coordinates from a colour source with a known latency of PIPE enabled
//   cycles. It then blanks the returned colour outside the active area. It
//   delays both syncs so that sync and colour leave the block together.
//
// Ports:
//   clock_25mhz             - the only clock, all logic on its rising edge
//   reset                   - synchronous active-high reset, overrides pix_en
//   pix_en                  - pixel-rate enable; nothing moves while it is 0
//   red/green/blue          - colour from the source for the coordinate that
//                             was presented PIPE enabled cycles earlier
//   red_out/green_out/...   - blanked colour to the DAC (latency PIPE+2)
//   horiz_sync_out          - horizontal sync, HS_POL level when asserted
//   vert_sync_out           - vertical sync, VS_POL level when asserted
//   pixel_col/pixel_row     - coordinate requested from the source; these
//                             read 0 outside the active area (latency 1)
//   video_on                - coordinate is inside the active area
//   line_start/frame_start  - pulses aligned with pixel_col for h=0 and for
//                             h=0,v=0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = 1,
    parameter int PIPE     = 1,
    parameter int CNT_W    = 10
) (
    input  logic               clock_25mhz,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic               horiz_sync_out,
    output logic               vert_sync_out,
    output logic [CNT_W-1:0]   pixel_col,
    output logic [CNT_W-1:0]   pixel_row,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic       HS_IDLE   = (HS_POL == 0) ? 1'b1 : 1'b0;
    localparam logic       VS_IDLE   = (VS_POL == 0) ? 1'b1 : 1'b0;
    localparam logic [1:0] SYNC_IDLE = {VS_IDLE, HS_IDLE};

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (pix_en) begin
            if (r_h_count == H_LAST) begin
                r_h_count <= '0;
                r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + CNT_W'(1);
            end else begin
                r_h_count <= r_h_count + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Decode of the current counter state
    // ---------------------------------------------------------------
    logic w_active;
    logic w_hs_level;
    logic w_vs_level;

    assign w_active   = (r_h_count < H_ACT_C) && (r_v_count < V_ACT_C);
    assign w_hs_level = ((r_h_count >= HS_FIRST_C) && (r_h_count <= HS_LAST_C)) ? ~HS_IDLE : HS_IDLE;
    assign w_vs_level = ((r_v_count >= VS_FIRST_C) && (r_v_count <= VS_LAST_C)) ? ~VS_IDLE : VS_IDLE;

    // ---------------------------------------------------------------
    // Coordinate stage: what the colour source sees, one enabled cycle
    // behind the counters.
    // ---------------------------------------------------------------
    logic             r_video_on;
    logic [CNT_W-1:0] r_pixel_col;
    logic [CNT_W-1:0] r_pixel_row;
    logic             r_line_start;
    logic             r_frame_start;

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            r_video_on    <= 1'b0;
            r_pixel_col   <= '0;
            r_pixel_row   <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_video_on    <= w_active;
            r_pixel_col   <= w_active ? r_h_count : '0;
            r_pixel_row   <= w_active ? r_v_count : '0;
            r_line_start  <= (r_h_count == '0);
            r_frame_start <= (r_h_count == '0) && (r_v_count == '0);
        end
    end

    // ---------------------------------------------------------------
    // video_on delay line, so the blanking mask lines up with the colour
    // returned by the source. Tap 0 is video_on itself and tap PIPE is
    // aligned with red/green/blue.
    // ---------------------------------------------------------------
    logic w_vid_tap [0:PIPE];
    assign w_vid_tap[0] = r_video_on;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_vid_stage
            logic r_vid;
            always_ff @(posedge clock_25mhz) begin
                if (reset) begin
                    r_vid <= 1'b0;
                end else if (pix_en) begin
                    r_vid <= w_vid_tap[gi];
                end
            end
            assign w_vid_tap[gi+1] = r_vid;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Sync delay line. The syncs pass through PIPE+2 stages: one stage for
    // the coordinate, PIPE stages for the source and one stage for the
    // colour output register. Bit 0 is hsync and bit 1 is vsync.
    // ---------------------------------------------------------------
    logic [1:0] w_sync_tap [0:PIPE+2];
    assign w_sync_tap[0] = {w_vs_level, w_hs_level};

    generate
        for (gi = 0; gi < PIPE + 2; gi++) begin : g_sync_stage
            logic [1:0] r_sync;
            always_ff @(posedge clock_25mhz) begin
                if (reset) begin
                    r_sync <= SYNC_IDLE;
                end else if (pix_en) begin
                    r_sync <= w_sync_tap[gi];
                end
            end
            assign w_sync_tap[gi+1] = r_sync;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Blanked colour output register
    // ---------------------------------------------------------------
    logic [COLOR_W-1:0] r_red_out;
    logic [COLOR_W-1:0] r_green_out;
    logic [COLOR_W-1:0] r_blue_out;

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            r_red_out   <= '0;
            r_green_out <= '0;
            r_blue_out  <= '0;
        end else if (pix_en) begin
            r_red_out   <= red   & {COLOR_W{w_vid_tap[PIPE]}};
            r_green_out <= green & {COLOR_W{w_vid_tap[PIPE]}};
            r_blue_out  <= blue  & {COLOR_W{w_vid_tap[PIPE]}};
        end
    end

    assign red_out        = r_red_out;
    assign green_out      = r_green_out;
    assign blue_out       = r_blue_out;
    assign horiz_sync_out = w_sync_tap[PIPE+2][0];
    assign vert_sync_out  = w_sync_tap[PIPE+2][1];
    assign pixel_col      = r_pixel_col;
    assign pixel_row      = r_pixel_row;
    assign video_on       = r_video_on;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose:
//   Self-checking bench for vga_timing_gen. It runs two instances side by
//   side:
//     - dut_d: the default 640x480 mode with PIPE=1.
//     - dut_s: a tiny mode with PIPE=3, active-high hsync, 3-bit colour and
//       CNT_W=5, so that whole frames and the vertical timing fit in a
//       short run.
//   Both instances share reset and pix_en. The reference model works from a
//   single number: how many enabled edges have occurred since the last
//   reset. From that it derives the raster position with div/mod and then
//   applies the timing rules directly. Directed phases measure the default
//   line period and the hsync width at full and half enable rate. The run
//   ends with a long phase of random enable, reset and colour.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, pipe;
    } mode_t;

    typedef struct {
        int r, g, b, hs, vs, von, col, row, ls, fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    // default-mode instance
    logic [0:0] d_r, d_g, d_b, d_ro, d_go, d_bo;
    logic       d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_col, d_row;

    // small-mode instance
    logic [2:0] s_r, s_g, s_b, s_ro, s_go, s_bo;
    logic       s_hs, s_vs, s_von, s_ls, s_fs;
    logic [4:0] s_col, s_row;

    int n_checks = 0;
    int n_errors = 0;

    mode_t m_def, m_sml;
    int    k;            // enabled edges since the last reset
    int    cyc;          // clock edges since the start of the run
    int    cd_r, cd_g, cd_b, cs_r, cs_g, cs_b; // colour captured at the last enabled edge

    // measurements on the default instance
    int   ls_period_exp, hs_width_exp;
    int   ls_last, hs_low;
    logic ls_prev;

    always #20 clk = ~clk;

    vga_timing_gen dut_d (
        .clock_25mhz   (clk),
        .reset         (rst),
        .pix_en        (en),
        .red           (d_r),
        .green         (d_g),
        .blue          (d_b),
        .red_out       (d_ro),
        .green_out     (d_go),
        .blue_out      (d_bo),
        .horiz_sync_out(d_hs),
        .vert_sync_out (d_vs),
        .pixel_col     (d_col),
        .pixel_row     (d_row),
        .video_on      (d_von),
        .line_start    (d_ls),
        .frame_start   (d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(5),  .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(1), .VS_POL(0), .COLOR_W(3), .PIPE(3), .CNT_W(5)
    ) dut_s (
        .clock_25mhz   (clk),
        .reset         (rst),
        .pix_en        (en),
        .red           (s_r),
        .green         (s_g),
        .blue          (s_b),
        .red_out       (s_ro),
        .green_out     (s_go),
        .blue_out      (s_bo),
        .horiz_sync_out(s_hs),
        .vert_sync_out (s_vs),
        .pixel_col     (s_col),
        .pixel_row     (s_row),
        .video_on      (s_von),
        .line_start    (s_ls),
        .frame_start   (s_fs)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d k=%0d got %0d expected %0d", tag, cyc, k, obs, exp);
        end
    endtask

    // Expected outputs after n enabled edges since reset. Coordinate
    // outputs describe raster position n-1. Colour and syncs describe raster
    // position n-pipe-2. Anything not yet reached still shows reset values.
    function automatic exp_t model(mode_t m, int n, int cr, int cg, int cb);
        exp_t e;
        int ht, vt, p, h, v;
        ht = m.ha + m.hf + m.hs + m.hb;
        vt = m.va + m.vf + m.vs + m.vb;
        e = '{default: 0};
        e.hs = 1 - m.hpol;
        e.vs = 1 - m.vpol;
        if (n >= 1) begin
            p = n - 1;
            h = p % ht;
            v = (p / ht) % vt;
            if (h < m.ha && v < m.va) begin
                e.von = 1;
                e.col = h;
                e.row = v;
            end
            e.ls = (h == 0) ? 1 : 0;
            e.fs = (h == 0 && v == 0) ? 1 : 0;
        end
        if (n >= m.pipe + 2) begin
            p = n - m.pipe - 2;
            h = p % ht;
            v = (p / ht) % vt;
            if (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) e.hs = m.hpol;
            if (v >= m.va + m.vf && v < m.va + m.vf + m.vs) e.vs = m.vpol;
            if (h < m.ha && v < m.va) begin
                e.r = cr;
                e.g = cg;
                e.b = cb;
            end
        end
        return e;
    endfunction

    task automatic check_all();
        exp_t e;
        e = model(m_def, k, cd_r, cd_g, cd_b);
        check_eq("d.red",   32'(d_ro),  e.r);
        check_eq("d.green", 32'(d_go),  e.g);
        check_eq("d.blue",  32'(d_bo),  e.b);
        check_eq("d.hsync", 32'(d_hs),  e.hs);
        check_eq("d.vsync", 32'(d_vs),  e.vs);
        check_eq("d.von",   32'(d_von), e.von);
        check_eq("d.col",   32'(d_col), e.col);
        check_eq("d.row",   32'(d_row), e.row);
        check_eq("d.lstart",32'(d_ls),  e.ls);
        check_eq("d.fstart",32'(d_fs),  e.fs);
        e = model(m_sml, k, cs_r, cs_g, cs_b);
        check_eq("s.red",   32'(s_ro),  e.r);
        check_eq("s.green", 32'(s_go),  e.g);
        check_eq("s.blue",  32'(s_bo),  e.b);
        check_eq("s.hsync", 32'(s_hs),  e.hs);
        check_eq("s.vsync", 32'(s_vs),  e.vs);
        check_eq("s.von",   32'(s_von), e.von);
        check_eq("s.col",   32'(s_col), e.col);
        check_eq("s.row",   32'(s_row), e.row);
        check_eq("s.lstart",32'(s_ls),  e.ls);
        check_eq("s.fstart",32'(s_fs),  e.fs);
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the
    // following falling edge.
    task automatic step(input logic rst_i, input logic en_i);
        rst = rst_i;
        en  = en_i;
        d_r = 1'($urandom);
        d_g = 1'($urandom);
        d_b = 1'($urandom);
        s_r = 3'($urandom);
        s_g = 3'($urandom);
        s_b = 3'($urandom);
        @(posedge clk);
        cyc++;
        if (rst_i) begin
            k = 0;
        end else if (en_i) begin
            k++;
            cd_r = int'(d_r); cd_g = int'(d_g); cd_b = int'(d_b);
            cs_r = int'(s_r); cs_g = int'(s_g); cs_b = int'(s_b);
        end
        @(negedge clk);
        check_all();
        if (d_ls && !ls_prev) begin
            if (ls_period_exp != 0 && ls_last >= 0)
                check_eq("d.line_period", ls_last >= 0 ? cyc - ls_last : 0, ls_period_exp);
            ls_last = cyc;
        end
        ls_prev = d_ls;
        if (d_hs == 1'b0) begin
            hs_low++;
        end else begin
            if (hs_low != 0 && hs_width_exp != 0)
                check_eq("d.hsync_width", hs_low, hs_width_exp);
            hs_low = 0;
        end
    endtask

    task automatic start_measure(input int period, input int width);
        ls_period_exp = period;
        hs_width_exp  = width;
        ls_last       = -1;
        ls_prev       = 1'b0;
        hs_low        = 0;
    endtask

    initial begin
        m_def = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
        m_sml = '{10, 2, 3, 4, 5, 1, 2, 3, 1, 0, 3};
        k = 0; cyc = 0;
        cd_r = 0; cd_g = 0; cd_b = 0; cs_r = 0; cs_g = 0; cs_b = 0;
        start_measure(0, 0);
        @(negedge clk);

        // Reset held with pix_en low and then high; both must give reset values.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        $display("reset phase done checks=%0d errors=%0d", n_checks, n_errors);

        // Full-rate enable: 800-clock line and 96-clock hsync.
        start_measure(800, 96);
        for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);
        $display("full-rate phase done checks=%0d errors=%0d", n_checks, n_errors);

        // Half-rate enable (1,0,...): 1600-clock line and 192-clock hsync.
        step(1'b1, 1'b0);
        start_measure(1600, 192);
        for (int i = 0; i < 3400; i++) step(1'b0, (i % 2) == 0);
        $display("half-rate phase done checks=%0d errors=%0d", n_checks, n_errors);

        // Random enable, colour and occasional mid-frame reset.
        start_measure(0, 0);
        for (int i = 0; i < 40000; i++)
            step($urandom_range(0, 2499) == 0, $urandom_range(0, 3) != 0);
        $display("random phase done checks=%0d errors=%0d", n_checks, n_errors);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameters HS_POL and VS_POL, default 0, giving the asserted sync level (0 = active-low).
REQ-010 SHALL have parameter COLOR_W, default 1, bits per colour channel.
REQ-011 SHALL have parameter PIPE, default 1, range 0..4, pixel-source latency in cycles.
REQ-012 SHALL have parameter CNT_W, default 10, counter and coordinate width.
REQ-013 SHALL have port clock_25mhz, input, 1 bit, the only clock; all logic is rising-edge.
REQ-014 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-015 SHALL have port pix_en, input, 1 bit, pixel-rate clock enable.
REQ-016 SHALL have ports red, green and blue, input, COLOR_W bits each, pixel colour from the source.
REQ-017 SHALL have ports red_out, green_out and blue_out, output, COLOR_W bits each, blanked colour to the DAC.
REQ-018 SHALL have ports horiz_sync_out and vert_sync_out, output, 1 bit each, sync lines.
REQ-019 SHALL have ports pixel_col and pixel_row, output, CNT_W bits each, coordinate requested from the source.
REQ-020 SHALL have port video_on, output, 1 bit, asserted when pixel_col/pixel_row are in the active area.
REQ-021 SHALL have ports line_start and frame_start, output, 1 bit each, single-cycle pulses.

Function
REQ-022 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; H_TOTAL-1 and V_TOTAL-1 SHALL fit in CNT_W bits.
REQ-023 SHALL advance all state only in cycles with pix_en=1; with pix_en=0 every register, including pipeline stages, SHALL hold.
REQ-024 SHALL count h_count 0..H_TOTAL-1 and wrap to 0.
REQ-025 SHALL increment v_count when h_count wraps, and wrap v_count to 0 when it is V_TOTAL-1 and h_count wraps.
REQ-026 SHALL produce h-sync active when H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1.
REQ-027 SHALL produce v-sync active when V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1, for entire lines.
REQ-028 SHALL define active = (h_count < H_ACTIVE) and (v_count < V_ACTIVE).
REQ-029 SHALL register video_on, pixel_col and pixel_row one enabled cycle after the counter state they describe.
REQ-030 SHALL output pixel_col = h_count and pixel_row = v_count while active, and 0 otherwise.
REQ-031 SHALL pulse line_start in the enabled cycle, aligned with pixel_col, where h_count=0.
REQ-032 SHALL pulse frame_start where h_count=0 and v_count=0.
REQ-033 SHALL treat red/green/blue as the colour for the coordinate presented PIPE enabled cycles earlier.
REQ-034 SHALL register the colour outputs as input colour AND video_on delayed PIPE stages, giving all zeros when blanked.
REQ-035 SHALL delay both syncs so that they are registered with the same PIPE+2 enabled-cycle latency from the counter as the colour outputs.
REQ-036 SHALL drive each sync output at the POL level while active and at the inverse level otherwise.

Reset
REQ-037 SHALL, on reset=1 at a clock edge regardless of pix_en, set h_count=0 and v_count=0 and clear all pipeline stages.
REQ-038 SHALL, during and directly after reset, drive colour outputs 0, syncs inactive (~POL), video_on=0, coordinates 0, and pulses 0.
REQ-039 SHALL treat reset mid-frame as an abort; the first enabled cycle after reset SHALL start a new frame with frame_start=1 after one cycle.

Verification
REQ-040 SHALL verify defaults with pix_en=1: h-sync low at h_count 656..751, line period 800 cycles, v-sync low at lines 490..491, frame period 420000 cycles.
REQ-041 SHALL verify blanking: with red=green=blue=1 constantly and PIPE=1, colour is 1 only for cols 0..639 and rows 0..479, and 0 for col 640 and row 480.
REQ-042 SHALL verify latency: with PIPE=3 and a source returning pixel_col[0] after 3 cycles, red_out toggles per pixel and col 0 is aligned with the first cycle after the sync/back-porch edge.
REQ-043 SHALL verify the enable: with pix_en toggling 1,0, the line period is 1600 clocks and all outputs hold during pix_en=0 cycles.
REQ-044 SHALL verify reset: reset=1 for 1 cycle at h=300, v=200 resets all outputs; frame_start pulses once 1 cycle after release.
REQ-045 SHALL verify a non-default mode: H=800/40/128/88, V=600/1/4/23, HS_POL=VS_POL=1, CNT_W=11 gives a 1056-cycle line, a 628-line frame, and active-high syncs.
